// File: rtl/layer1_result_window_reader_if.sv
// Bundle between the layer-1 result window reader, the layer-1 result store
// read port and the layer-2 window consumer.
//
// Window handshake: a window transfers on a rising clk edge where win_valid
// and win_ready are both high. Once win_valid rises, it stays high and
// win_data/win_row/win_col stay stable until that transfer. win_ready
// sampled while win_valid is low has no effect.
interface layer1_result_window_reader_if #(
  parameter int DATA_W = 128,
  parameter int K      = 3
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    mem_read_signal;
  logic [15:0]             mem_read_row_addr;
  logic [15:0]             mem_read_col_addr;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    win_valid;
  logic                    win_ready;
  logic [K*K*DATA_W-1:0]   win_data;
  logic [15:0]             win_row;
  logic [15:0]             win_col;
  logic [1:0]              dbg_state;

  // Reader side
  modport master (
    input  start, mem_rdata, win_ready,
    output busy, done, mem_read_signal, mem_read_row_addr, mem_read_col_addr,
           win_valid, win_data, win_row, win_col, dbg_state
  );

  // Environment side (store read port, consumer, controller)
  modport slave (
    output start, mem_rdata, win_ready,
    input  busy, done, mem_read_signal, mem_read_row_addr, mem_read_col_addr,
           win_valid, win_data, win_row, win_col, dbg_state
  );
endinterface

// File: rtl/layer1_result_window_reader.sv
// Layer-1 result window reader: sweeps every KxK neighbourhood of the
// ROWS x COLS result store in raster order, reads one entry per cycle
// (combinational read port), assembles the window and offers it to the
// layer-2 stage. Each window costs K*K fetch cycles plus one output cycle.
module layer1_result_window_reader #(
  parameter int ROWS   = 30,
  parameter int COLS   = 30,
  parameter int DATA_W = 128,
  parameter int K      = 3
) (
  input  logic clk,
  input  logic rst,
  layer1_result_window_reader_if.master bus
);

  localparam int NE = K * K;
  localparam int KW = (NE > 1) ? $clog2(NE) : 1;
  localparam int OW = (K > 1) ? $clog2(K) : 1;

  localparam logic [15:0]   LAST_ROW = 16'(ROWS - K);
  localparam logic [15:0]   LAST_COL = 16'(COLS - K);
  localparam logic [KW-1:0] LAST_K   = KW'(NE - 1);
  localparam logic [OW-1:0] LAST_OFF = OW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OUT   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [15:0]           r_base_row;
  logic [15:0]           r_base_col;
  logic [KW-1:0]         r_k;
  // Row/column offset inside the window, tracked alongside r_k so the read
  // address never needs a divide by K.
  logic [OW-1:0]         r_kr;
  logic [OW-1:0]         r_kc;
  logic [NE*DATA_W-1:0]  r_win;

  logic w_fetch;
  logic w_last_base;

  assign w_fetch     = (r_state == S_FETCH);
  assign w_last_base = (r_base_row == LAST_ROW) && (r_base_col == LAST_COL);

  // All status outputs decode straight from the state register.
  assign bus.busy              = (r_state != S_IDLE);
  assign bus.done              = (r_state == S_DONE);
  assign bus.win_valid         = (r_state == S_OUT);
  assign bus.mem_read_signal   = w_fetch;
  assign bus.mem_read_row_addr = w_fetch ? (r_base_row + 16'(r_kr)) : 16'd0;
  assign bus.mem_read_col_addr = w_fetch ? (r_base_col + 16'(r_kc)) : 16'd0;
  assign bus.win_data          = r_win;
  assign bus.win_row           = r_base_row;
  assign bus.win_col           = r_base_col;
  assign bus.dbg_state         = r_state;

  // Sweep sequencer: fetch K*K entries, present the window, advance the base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base_row <= 16'd0;
      r_base_col <= 16'd0;
      r_k        <= '0;
      r_kr       <= '0;
      r_kc       <= '0;
      r_win      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_FETCH;
            r_base_row <= 16'd0;
            r_base_col <= 16'd0;
            r_k        <= '0;
            r_kr       <= '0;
            r_kc       <= '0;
          end
        end
        S_FETCH: begin
          for (int e = 0; e < NE; e++) begin
            if (r_k == KW'(e)) r_win[e*DATA_W +: DATA_W] <= bus.mem_rdata;
          end
          if (r_k == LAST_K) begin
            r_state <= S_OUT;
          end else begin
            r_k <= r_k + 1'b1;
            if (r_kc == LAST_OFF) begin
              r_kc <= '0;
              r_kr <= r_kr + 1'b1;
            end else begin
              r_kc <= r_kc + 1'b1;
            end
          end
        end
        S_OUT: begin
          // Window is held until the consumer takes it; no re-reads meanwhile.
          if (bus.win_ready) begin
            if (w_last_base) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_FETCH;
              r_k     <= '0;
              r_kr    <= '0;
              r_kc    <= '0;
              if (r_base_col == LAST_COL) begin
                r_base_col <= 16'd0;
                r_base_row <= r_base_row + 16'd1;
              end else begin
                r_base_col <= r_base_col + 16'd1;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer1_result_window_reader.sv
// Directed bench for layer1_result_window_reader: full sweep with start
// re-pulse, backpressure hold, asynchronous reset mid-fetch, restart.
module tb_layer1_result_window_reader;

  localparam int DW = 128;
  localparam int KK = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer1_result_window_reader_if #(.DATA_W(DW), .K(KK)) bus();

  layer1_result_window_reader #(
    .ROWS(30), .COLS(30), .DATA_W(DW), .K(KK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Preloaded result store with a combinational read port.
  logic [DW-1:0] mem [0:29][0:29];
  initial begin
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 30; c++)
        mem[r][c] = {112'd0, 8'(r), 8'(c)};
  end
  assign bus.mem_rdata = (bus.mem_read_row_addr < 16'd30 && bus.mem_read_col_addr < 16'd30)
                         ? mem[bus.mem_read_row_addr[4:0]][bus.mem_read_col_addr[4:0]] : '0;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];  // expected window bases {row, col} in raster order

  function automatic logic [DW-1:0] model(input int r, input int c);
    return {112'd0, 8'(r), 8'(c)};
  endfunction

  function automatic logic [DW-1:0] elem(input logic [KK*KK*DW-1:0] d, input int e);
    return d[e*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int cur_r, cur_c, er, ec;
  int fetch_in_win, fetch_total, xfers, first_valid, done_cnt, done_cyc;
  int bound_err, addr_err, order_err, data_err, fetch_err, bp_err, lat;
  logic busy_after;
  logic found;
  logic [31:0] b;
  logic [KK*KK*DW-1:0] snap_data;
  logic [15:0] snap_row, snap_col;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.win_ready = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_busy",      bus.busy, 1'b0);
    chk("rst_done",      bus.done, 1'b0);
    chk("rst_valid",     bus.win_valid, 1'b0);
    chk("rst_rd",        bus.mem_read_signal, 1'b0);
    chk("rst_row_addr",  bus.mem_read_row_addr, 16'd0);
    chk("rst_col_addr",  bus.mem_read_col_addr, 16'd0);
    chk("rst_win_row",   bus.win_row, 16'd0);
    chk("rst_win_col",   bus.win_col, 16'd0);
    chk("rst_win_data0", (bus.win_data === '0), 1'b1);
    chk("rst_state",     bus.dbg_state, 2'd0);
    rst = 1'b0;
    step();

    // ---- Sweep 1: full sweep, win_ready high, start re-pulsed at window 100
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        exp_q.push_back({16'(r), 16'(c)});
    fetch_in_win = 0; fetch_total = 0; xfers = 0; first_valid = -1;
    done_cnt = 0; done_cyc = -10; bound_err = 0; addr_err = 0;
    order_err = 0; data_err = 0; fetch_err = 0; busy_after = 1'b1;
    cur_r = 0; cur_c = 0;
    bus.win_ready = 1'b1;
    bus.start = 1'b1;
    step();  // this edge accepts start; cycle 0 below
    for (int cyc = 0; cyc <= 7850; cyc++) begin
      bus.start = 1'b0;
      if (exp_q.size() > 0) begin
        cur_r = int'(exp_q[0][31:16]);
        cur_c = int'(exp_q[0][15:0]);
      end
      if (bus.mem_read_signal) begin
        fetch_total++;
        if (bus.mem_read_row_addr > 16'd29 || bus.mem_read_col_addr > 16'd29) bound_err++;
        if (int'(bus.mem_read_row_addr) != cur_r + fetch_in_win / 3 ||
            int'(bus.mem_read_col_addr) != cur_c + fetch_in_win % 3) addr_err++;
        if (bus.win_valid) addr_err++;
        fetch_in_win++;
      end
      if (bus.win_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) begin
          order_err++;
        end else begin
          b  = exp_q.pop_front();
          er = int'(b[31:16]);
          ec = int'(b[15:0]);
          if (int'(bus.win_row) != er || int'(bus.win_col) != ec) order_err++;
          for (int e = 0; e < 9; e++)
            if (elem(bus.win_data, e) !== model(er + e / 3, ec + e % 3)) data_err++;
          if (xfers == 0) begin
            chk("first_row",   bus.win_row, 16'd0);
            chk("first_col",   bus.win_col, 16'd0);
            chk("first_elem0", elem(bus.win_data, 0), 128'h0000);
            chk("first_elem4", elem(bus.win_data, 4), 128'h0101);
            chk("first_elem8", elem(bus.win_data, 8), 128'h0202);
          end
          if (er == 27 && ec == 27) begin
            chk("last_row",   bus.win_row, 16'd27);
            chk("last_col",   bus.win_col, 16'd27);
            chk("last_elem8", elem(bus.win_data, 8), 128'h1D1D);
          end
        end
        if (fetch_in_win != 9) fetch_err++;
        fetch_in_win = 0;
        xfers++;
        if (xfers == 100) bus.start = 1'b1;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = bus.busy;
      step();
    end
    chk("first_valid_latency", 128'(first_valid), 128'd9);
    chk("xfer_count",          128'(xfers), 128'd784);
    chk("queue_drained",       128'(exp_q.size()), 128'd0);
    chk("done_pulses",         128'(done_cnt), 128'd1);
    chk("done_cycle",          128'(done_cyc), 128'd7840);
    chk("busy_after_done",     busy_after, 1'b0);
    chk("idle_at_end",         bus.busy, 1'b0);
    chk("addr_bound_errs",     128'(bound_err), 128'd0);
    chk("addr_value_errs",     128'(addr_err), 128'd0);
    chk("raster_order_errs",   128'(order_err), 128'd0);
    chk("window_data_errs",    128'(data_err), 128'd0);
    chk("fetch_per_win_errs",  128'(fetch_err), 128'd0);
    chk("fetch_total",         128'(fetch_total), 128'(784 * 9));

    // ---- Sweep 2: backpressure on window (0,5), then reset mid-fetch of (3,4)
    bus.win_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.win_valid && bus.win_row == 16'd0 && bus.win_col == 16'd5) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("bp_reach_0_5", found, 1'b1);
    bus.win_ready = 1'b0;
    snap_data = bus.win_data;
    snap_row  = bus.win_row;
    snap_col  = bus.win_col;
    bp_err = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.win_valid !== 1'b1) bp_err++;
      if (bus.win_data !== snap_data || bus.win_row !== snap_row || bus.win_col !== snap_col) bp_err++;
      if (bus.mem_read_signal !== 1'b0) bp_err++;
    end
    chk("bp_hold_errs",   128'(bp_err), 128'd0);
    chk("bp_still_valid", bus.win_valid, 1'b1);
    chk("bp_col",         bus.win_col, 16'd5);
    chk("bp_elem8",       elem(bus.win_data, 8), 128'h0207);
    bus.win_ready = 1'b1;
    step();  // transfer edge
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.win_valid) begin
        lat = i;
        break;
      end
      step();
    end
    chk("after_bp_latency", 128'(lat), 128'd9);
    chk("after_bp_row",     bus.win_row, 16'd0);
    chk("after_bp_col",     bus.win_col, 16'd6);
    chk("after_bp_elem4",   elem(bus.win_data, 4), 128'h0107);

    found = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (bus.win_valid && bus.win_row == 16'd3 && bus.win_col == 16'd3) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("reach_3_3", found, 1'b1);
    step();            // transfer edge, FETCH of (3,4) with k=0
    repeat (3) step(); // k=3 -> offset (1,0)
    chk("mid_fetch_rd",   bus.mem_read_signal, 1'b1);
    chk("mid_fetch_row",  bus.mem_read_row_addr, 16'd4);
    chk("mid_fetch_col",  bus.mem_read_col_addr, 16'd4);
    chk("mid_fetch_wcol", bus.win_col, 16'd4);
    #2;
    rst = 1'b1;
    #1;  // no clock edge between assertion and these samples
    chk("arst_busy",     bus.busy, 1'b0);
    chk("arst_valid",    bus.win_valid, 1'b0);
    chk("arst_rd",       bus.mem_read_signal, 1'b0);
    chk("arst_row_addr", bus.mem_read_row_addr, 16'd0);
    chk("arst_col_addr", bus.mem_read_col_addr, 16'd0);
    chk("arst_win_row",  bus.win_row, 16'd0);
    chk("arst_win_col",  bus.win_col, 16'd0);
    chk("arst_win_data", (bus.win_data === '0), 1'b1);
    chk("arst_done",     bus.done, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // ---- Sweep 3: restart after reset
    bus.win_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.win_valid) begin
        lat = i;
        break;
      end
      step();
    end
    chk("restart_latency", 128'(lat), 128'd9);
    chk("restart_row",     bus.win_row, 16'd0);
    chk("restart_col",     bus.win_col, 16'd0);
    chk("restart_elem0",   elem(bus.win_data, 0), 128'h0000);
    chk("restart_elem4",   elem(bus.win_data, 4), 128'h0101);
    chk("restart_elem8",   elem(bus.win_data, 8), 128'h0202);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer1_result_window_reader.md
Name: layer1_result_window_reader

Overview:
- Read-side sequencer for the layer-1 result store (30x30 grid of 128-bit entries, combinational read port).
- Walks every valid 3x3 neighbourhood in raster order and issues one row/col read address per cycle.
- Gathers the 9 returned entries into one flat window and hands it to the layer-2 compute stage over a valid/ready handshake.
- Sits between the layer-1 result memory and the layer-2 convolution engine; started once layer 1 has finished writing.

Parameters:
- ROWS, 30, rows in the result store
- COLS, 30, columns in the result store
- DATA_W, 128, width of one stored result entry
- K, 3, window edge length (window holds K*K entries)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a full sweep; sampled only in IDLE
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last window is accepted
- mem_read_signal  output  1  read enable to result store
- mem_read_row_addr  output  16  read row address
- mem_read_col_addr  output  16  read column address
- mem_rdata  input  DATA_W  read data; combinational, valid in the same cycle as the address
- win_valid  output  1  window available
- win_ready  input  1  consumer accepts window
- win_data  output  K*K*DATA_W  window; element k=kr*K+kc at [k*DATA_W +: DATA_W]
- win_row  output  16  top-left row of the current window
- win_col  output  16  top-left column of the current window

Behaviour:
- Clock is clk. Reset is rst, asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; window base (0,0); element counter 0; win_data cleared.
- States:
  - IDLE: start=1 -> FETCH, base (0,0), k=0.
  - FETCH: mem_read_signal=1, row address = base_row+kr, col address = base_col+kc. mem_rdata is captured into element k at each edge, then k increments. Capture of k=K*K-1 -> OUT.
  - OUT: win_valid=1; win_data, win_row, win_col held stable. On win_valid&win_ready at an edge:
    - if base=(ROWS-K, COLS-K) -> DONE;
    - else advance base (column fastest, 0..COLS-K, then row), k=0, -> FETCH.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Outside FETCH: mem_read_signal=0 and both addresses 0.
- Latency:
  - FETCH entered on the edge sampling start.
  - win_valid rises after the 9th capture edge, i.e. 9 cycles after start acceptance.
  - With win_ready held high, one window per 10 cycles.
  - Full 30x30 sweep is 28*28 = 784 windows = 7840 cycles, then the done pulse.
- Handshake:
  - win_valid never drops without a transfer.
  - win_ready while not valid is ignored.
  - Backpressure holds OUT indefinitely with no re-reads.
- start while busy is ignored; no restart mid-sweep.
- Windows never wrap or cross the grid edge. Max address is ROWS-1 / COLS-1. Address arithmetic is 16-bit, zero-extended.
- rst mid-sweep: immediate return to IDLE with reset values; a partially assembled window is discarded.
- Counters: window base counters sized to 16 bits; element counter sized ceil(log2(K*K)).

Test Plan:
- Preload mem[r][c] = {112'd0, r[7:0], c[7:0]}. Pulse start, hold win_ready=1. Required response:
  - first win_valid 9 cycles after start;
  - win_row=0, win_col=0;
  - element0=0x0000, element4=0x0101, element8=0x0202.
- Full sweep with win_ready=1:
  - exactly 784 transfers, raster order (0,0),(0,1)..(0,27),(1,0)..;
  - last window (27,27) with element8=0x1D1D;
  - done high for exactly 1 cycle, 7840 cycles after start acceptance;
  - busy low on the following cycle.
- Backpressure: hold win_ready=0 for 50 cycles on window (0,5).
  - win_valid stays 1, and win_data, win_row, win_col do not change.
  - mem_read_signal=0 throughout.
  - Release win_ready -> next window is (0,6).
- Re-pulse start at window 100. Required: no effect; the sweep still ends after 784 windows with a single done pulse.
- Assert rst during FETCH of window (3,4).
  - All outputs go to 0 asynchronously.
  - After release and a new start, the first window is (0,0) with correct data.
- Address bound check across the full sweep: mem_read_row_addr and mem_read_col_addr never exceed 29; mem_read_signal=1 only in FETCH, exactly 9 cycles per window.
